// File: rtl/trdb_pkg.sv
// trdb_pkg: shared trace-debug types and widths
package trdb_pkg;
   localparam int XLEN = 32;
   localparam int QEV_CNT_LEN = 16;
   typedef enum logic [1:0] {
      QEV_NONE  = 2'b00,
      QEV_START = 2'b01,
      QEV_STOP  = 2'b10
   } trdb_qev_e;
endpackage

// File: rtl/trdb_qev_fifo.sv
// trdb_qev_fifo: register FIFO for qualification events, head zeroed while empty
module trdb_qev_fifo #(
   parameter int DEPTH = 2,
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push,
   input  logic [W-1:0] din,
   output logic         full,
   input  logic         pop,
   output logic         empty,
   output logic [W-1:0] head
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW:0] wr_q, rd_q;
   logic wr_en, rd_en;
   assign empty = wr_q == rd_q;
   assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   // a pop frees the slot being written, so push at full succeeds alongside it
   assign wr_en = push & (~full | pop);
   assign rd_en = pop & ~empty;
   assign head = empty ? '0 : mem[rd_q[AW-1:0]];
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_q + (AW+1)'(wr_en);
         rd_q <= rd_q + (AW+1)'(rd_en);
      end
   end
   always_ff @(posedge clk_i) begin
      if (wr_en) mem[wr_q[AW-1:0]] <= din;
   end
endmodule

// File: rtl/trdb_qual_tracker.sv
// trdb_qual_tracker: turns qualification edges into buffered START/STOP events
module trdb_qual_tracker
   import trdb_pkg::*;
#(
   parameter int QEV_DEPTH = 2,
   parameter int CNT_LEN = QEV_CNT_LEN
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               ivalid_i,
   input  logic [XLEN-1:0]    iaddr_i,
   input  logic               trace_qualified_i,
   input  logic               flush_i,
   output logic               ev_valid_o,
   input  logic               ev_ready_i,
   output trdb_qev_e          ev_type_o,
   output logic [XLEN-1:0]    ev_addr_o,
   output logic [CNT_LEN-1:0] ev_count_o,
   output logic               overflow_o,
   input  logic               clear_overflow_i,
   output logic               qualified_o
);
   localparam int W = 2 + XLEN + CNT_LEN;
   logic qual_q, qual_d, push, full, empty, pop, ovf_q;
   logic [XLEN-1:0] last_q, last_d, addr;
   logic [CNT_LEN-1:0] skip_q, skip_d, cnt;
   trdb_qev_e typ;
   logic [1:0] head_typ;
   logic [W-1:0] head;
   always_comb begin
      push = 1'b0;
      typ = QEV_NONE;
      addr = last_q;
      cnt = '0;
      qual_d = qual_q;
      last_d = last_q;
      skip_d = skip_q;
      // a flush swallows any instruction retiring in the same cycle
      if (flush_i) begin
         if (qual_q) begin
            push = 1'b1;
            typ = QEV_STOP;
            qual_d = 1'b0;
            skip_d = '0;
         end
      end else if (ivalid_i) begin
         if (trace_qualified_i) begin
            if (!qual_q) begin
               push = 1'b1;
               typ = QEV_START;
               addr = iaddr_i;
               cnt = skip_q;
               skip_d = '0;
               qual_d = 1'b1;
            end
            last_d = iaddr_i;
         end else if (qual_q) begin
            push = 1'b1;
            typ = QEV_STOP;
            qual_d = 1'b0;
            skip_d = CNT_LEN'(1);
         end else begin
            skip_d = &skip_q ? skip_q : skip_q + 1'b1;
         end
      end
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         qual_q <= 1'b0;
         last_q <= '0;
         skip_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         qual_q <= qual_d;
         last_q <= last_d;
         skip_q <= skip_d;
         ovf_q <= (push & full & ~pop) | (ovf_q & ~clear_overflow_i);
      end
   end
   assign pop = ev_ready_i & ~empty;
   trdb_qev_fifo #(.DEPTH(QEV_DEPTH), .W(W)) u_fifo (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .push(push),
      .din({typ, addr, cnt}),
      .full(full),
      .pop(pop),
      .empty(empty),
      .head(head)
   );
   assign {head_typ, ev_addr_o, ev_count_o} = head;
   assign ev_type_o = trdb_qev_e'(head_typ);
   assign ev_valid_o = ~empty;
   assign overflow_o = ovf_q;
   assign qualified_o = qual_q;
endmodule

// File: tb/tb_trdb_qual_tracker.sv
// tb_trdb_qual_tracker: scoreboard bench with an event-level reference model
module tb_trdb_qual_tracker;
   import trdb_pkg::*;
   localparam int DEPTH = 2;
   localparam int SKIP_MAX = 2**16 - 1;
   typedef struct packed {
      logic [1:0]  t;
      logic [31:0] a;
      logic [15:0] c;
   } ev_t;
   logic clk_i = 1'b0, rst_i = 1'b1;
   logic ivalid_i = 1'b0, trace_qualified_i = 1'b0, flush_i = 1'b0;
   logic ev_ready_i = 1'b0, clear_overflow_i = 1'b0;
   logic [31:0] iaddr_i = '0;
   logic ev_valid_o, overflow_o, qualified_o;
   trdb_qev_e ev_type_o;
   logic [31:0] ev_addr_o;
   logic [15:0] ev_count_o;
   int checks = 0, failures = 0;
   ev_t exp_q[$];
   bit m_qual = 0, m_ovf = 0;
   logic [31:0] m_last = '0;
   int m_skip = 0;

   trdb_qual_tracker #(.QEV_DEPTH(DEPTH), .CNT_LEN(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .ivalid_i(ivalid_i), .iaddr_i(iaddr_i),
      .trace_qualified_i(trace_qualified_i), .flush_i(flush_i),
      .ev_valid_o(ev_valid_o), .ev_ready_i(ev_ready_i), .ev_type_o(ev_type_o),
      .ev_addr_o(ev_addr_o), .ev_count_o(ev_count_o), .overflow_o(overflow_o),
      .clear_overflow_i(clear_overflow_i), .qualified_o(qualified_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // drive one cycle; the model advances right after the clock edge
   task automatic cyc(input bit iv, input bit tq, input logic [31:0] a,
                      input bit fl, input bit rdy, input bit clr);
      bit has_ev, pop_e, drop, nq;
      ev_t e;
      logic [31:0] nl;
      int ns, occ;
      ivalid_i = iv; trace_qualified_i = tq; iaddr_i = a;
      flush_i = fl; ev_ready_i = rdy; clear_overflow_i = clr;
      occ = exp_q.size();
      pop_e = rdy && occ > 0;
      has_ev = 0; e = '0; nq = m_qual; nl = m_last; ns = m_skip;
      if (fl) begin
         if (m_qual) begin has_ev = 1; e.t = 2'b10; e.a = m_last; nq = 0; ns = 0; end
      end else if (iv) begin
         if (tq && !m_qual) begin
            has_ev = 1; e.t = 2'b01; e.a = a; e.c = 16'(m_skip); ns = 0; nq = 1; nl = a;
         end else if (tq) nl = a;
         else if (m_qual) begin has_ev = 1; e.t = 2'b10; e.a = m_last; nq = 0; ns = 1; end
         else ns = (m_skip < SKIP_MAX) ? m_skip + 1 : SKIP_MAX;
      end
      @(posedge clk_i); #1;
      drop = has_ev && occ >= DEPTH && !pop_e;
      if (has_ev && !drop) exp_q.push_back(e);
      m_ovf = drop ? 1'b1 : clr ? 1'b0 : m_ovf;
      m_qual = nq; m_last = nl; m_skip = ns;
   endtask

   always @(negedge clk_i) begin
      ev_t e;
      if (!rst_i) begin
         chk("ev_valid", 32'(ev_valid_o), 32'(exp_q.size() != 0));
         chk("overflow", 32'(overflow_o), 32'(m_ovf));
         chk("qualified", 32'(qualified_o), 32'(m_qual));
         if (ev_valid_o && ev_ready_i) begin
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_pop: got type %0d addr %h, expected no event", ev_type_o, ev_addr_o);
            end else begin
               e = exp_q.pop_front();
               chk("ev_type", 32'(ev_type_o), 32'(e.t));
               chk("ev_addr", ev_addr_o, e.a);
               chk("ev_count", 32'(ev_count_o), 32'(e.c));
            end
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_valid", 32'(ev_valid_o), 0);
      chk("rst_type", 32'(ev_type_o), 0);
      chk("rst_addr", ev_addr_o, 0);
      chk("rst_count", 32'(ev_count_o), 0);
      chk("rst_ovf", 32'(overflow_o), 0);
      chk("rst_qual", 32'(qualified_o), 0);
      rst_i = 1'b0;
      repeat (3) cyc(1, 0, 32'h10, 0, 1, 0);
      cyc(1, 1, 32'h100, 0, 1, 0);
      cyc(1, 1, 32'h104, 0, 1, 0);
      cyc(1, 1, 32'h108, 0, 1, 0);
      cyc(1, 0, 32'h200, 0, 1, 0);
      repeat (2) cyc(1, 0, 32'h204, 0, 1, 0);
      cyc(1, 1, 32'h300, 0, 1, 0);
      cyc(1, 0, 32'h304, 0, 0, 0);
      cyc(1, 1, 32'h400, 0, 0, 0);
      cyc(1, 0, 32'h404, 0, 0, 0);
      cyc(0, 0, 32'h0, 0, 0, 1);
      cyc(1, 1, 32'h500, 0, 0, 1);
      repeat (3) cyc(0, 0, 32'h0, 0, 1, 0);
      cyc(0, 0, 32'h0, 0, 1, 1);
      cyc(1, 1, 32'h40, 0, 1, 0);
      cyc(1, 1, 32'h44, 0, 1, 0);
      cyc(1, 1, 32'h48, 1, 1, 0);
      cyc(1, 1, 32'h50, 0, 1, 0);
      for (int i = 0; i < 65536 + 6; i++) cyc(1, 0, 32'h60, 0, 1, 0);
      cyc(1, 1, 32'h700, 0, 1, 0);
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom & 32'hfffc,
             $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
      repeat (3) cyc(0, 0, 32'h0, 1, 1, 1);
      cyc(1, 0, 32'h800, 0, 0, 0);
      cyc(1, 1, 32'h804, 0, 0, 0);
      cyc(1, 0, 32'h808, 0, 0, 0);
      chk("pre_rst_depth", 32'(exp_q.size()), 2);
      #2 rst_i = 1'b1;
      #1;
      chk("arst_valid", 32'(ev_valid_o), 0);
      chk("arst_type", 32'(ev_type_o), 0);
      chk("arst_addr", ev_addr_o, 0);
      chk("arst_count", 32'(ev_count_o), 0);
      chk("arst_ovf", 32'(overflow_o), 0);
      chk("arst_qual", 32'(qualified_o), 0);
      exp_q.delete();
      m_qual = 0; m_ovf = 0; m_last = '0; m_skip = 0;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      cyc(1, 0, 32'h900, 0, 1, 0);
      cyc(1, 1, 32'h904, 0, 1, 0);
      repeat (3) cyc(0, 0, 32'h0, 0, 1, 0);
      chk("drained", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
